p405s_icu_fill_rdbuf: RTL and testbench

P405S_ICU_FILL_RDBUF -- requirements
Module: p405s_icu_fill_rdbuf

---
 rtl/p405s_icu_fill_rdbuf_if.sv | 41 ++++
 rtl/p405s_icu_fill_rdbuf.sv | 148 ++++++++++++++
 tb/tb_p405s_icu_fill_rdbuf.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/p405s_icu_fill_rdbuf_if.sv
// ============================================================================
// p405s_icu_fill_rdbuf_if : fill/fetch bus of the ICU fill read buffer
// Rev 1.0 ; optional parity signals under ICU_RDBUF_PARITY_EN
// ============================================================================
`default_nettype none

interface p405s_icu_fill_rdbuf_if;
  logic        fillVld;
  logic [0:31] fillData;
  logic        fillRdy;
  logic        fillFlush;
  logic        fetchRd;
  logic        fetchVld;
  logic [0:31] fetchData;
  logic        lineDone;
  logic [0:3]  bufCnt;
`ifdef ICU_RDBUF_PARITY_EN
  logic        fillPar;
  logic        fetchParErr;

  modport master (
    output fillVld, fillData, fillFlush, fetchRd, fillPar,
    input  fillRdy, fetchVld, fetchData, lineDone, bufCnt, fetchParErr
  );
  modport slave (
    input  fillVld, fillData, fillFlush, fetchRd, fillPar,
    output fillRdy, fetchVld, fetchData, lineDone, bufCnt, fetchParErr
  );
`else
  modport master (
    output fillVld, fillData, fillFlush, fetchRd,
    input  fillRdy, fetchVld, fetchData, lineDone, bufCnt
  );
  modport slave (
    input  fillVld, fillData, fillFlush, fetchRd,
    output fillRdy, fetchVld, fetchData, lineDone, bufCnt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/p405s_icu_fill_rdbuf.sv
// ============================================================================
// p405s_icu_fill_rdbuf : ICU fill-word FIFO with cache-line completion tracking
// Rev 1.0 ; macro ICU_RDBUF_PARITY_EN adds per-entry fill parity checking
// ============================================================================
`default_nettype none

module p405s_icu_fill_rdbuf #(
  parameter int DEPTH      = 4,
  parameter int LINE_WORDS = 8
) (
  input  wire logic              CB,
  input  wire logic              resetL,
  p405s_icu_fill_rdbuf_if.slave  bus
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              WC_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(LINE_WORDS - 1);
  localparam logic [3:0]      CNT_FULL = 4'(DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [WC_W-1:0]   wcnt_q,      wcnt_d;
  logic              line_done_q, line_done_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];

  logic              wr_en;
  logic              rd_en;
  logic              not_empty;
  logic [31:0]       head_word;

  assign not_empty = (cnt_q != 4'd0);
  // Full-buffer readiness ignores a same-cycle read: there is no full bypass.
  assign wr_en     = bus.fillVld && (cnt_q < CNT_FULL);
  assign rd_en     = bus.fetchRd && not_empty;
  assign head_word = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wcnt_d      = wcnt_q;
    line_done_d = 1'b0;
    mem_d       = mem_q;

    if (bus.fillFlush) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wcnt_d   = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = bus.fillData;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        cnt_d = cnt_q + 4'd1;
      end else if (rd_en && !wr_en) begin
        cnt_d = cnt_q - 4'd1;
      end

      case (state_q)
        IDLE: begin
          if (wr_en) begin
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (rd_en) begin
            if (wcnt_q == WC_LAST) begin
              wcnt_d      = '0;
              line_done_d = 1'b1;
              if (cnt_d == 4'd0) begin
                state_d = IDLE;
              end
            end else begin
              wcnt_d = wcnt_q + WC_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CB) begin
    if (!resetL) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wcnt_q      <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wcnt_q      <= wcnt_d;
      line_done_q <= line_done_d;
    end
  end

  // Storage needs no reset: stale entries are never visible while empty.
  always_ff @(posedge CB) begin
    mem_q <= mem_d;
  end

  assign bus.fillRdy   = (cnt_q < CNT_FULL);
  assign bus.fetchVld  = not_empty;
  assign bus.fetchData = not_empty ? head_word : 32'd0;
  assign bus.lineDone  = line_done_q;
  assign bus.bufCnt    = cnt_q;

`ifdef ICU_RDBUF_PARITY_EN
  logic par_q [DEPTH];
  logic par_d [DEPTH];

  always_comb begin
    par_d = par_q;
    if (!bus.fillFlush && wr_en) begin
      par_d[wr_ptr_q] = bus.fillPar;
    end
  end

  always_ff @(posedge CB) begin
    par_q <= par_d;
  end

  assign bus.fetchParErr = not_empty && ((^head_word) != par_q[rd_ptr_q]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_p405s_icu_fill_rdbuf.sv
// ============================================================================
// tb_p405s_icu_fill_rdbuf : scoreboard bench for the ICU fill read buffer
// Rev 1.0 ; parity scenario built only with ICU_RDBUF_PARITY_EN
// ============================================================================
`default_nettype none

module tb_p405s_icu_fill_rdbuf;
  localparam int DEPTH = 4;
  localparam int LW    = 8;

  logic clk    = 1'b0;
  logic resetL = 1'b0;

  p405s_icu_fill_rdbuf_if intf ();

  p405s_icu_fill_rdbuf #(
    .DEPTH      (DEPTH),
    .LINE_WORDS (LW)
  ) dut (
    .CB     (clk),
    .resetL (resetL),
    .bus    (intf.slave)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          m_cnt  = 0;
  int          m_wc   = 0;
  logic        m_done = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock of stimulus; the reference model advances at the same edge.
  task automatic tick(input logic vld, input logic [31:0] d, input logic rd, input logic fl);
    bit wr, rdo;
    intf.fillVld   = vld;
    intf.fillData  = d;
    intf.fetchRd   = rd;
    intf.fillFlush = fl;
    wr  = vld && (m_cnt < DEPTH);
    rdo = rd && (m_cnt > 0);
    @(posedge clk);
    if (!resetL || fl) begin
      exp_q.delete();
      m_cnt  = 0;
      m_wc   = 0;
      m_done = 1'b0;
    end else begin
      m_done = rdo && (m_wc == LW - 1);
      if (rdo) begin
        void'(exp_q.pop_front());
        m_cnt--;
        m_wc = (m_wc == LW - 1) ? 0 : m_wc + 1;
      end
      if (wr) begin
        exp_q.push_back(d);
        m_cnt++;
      end
    end
    #1;
    intf.fillVld   = 1'b0;
    intf.fetchRd   = 1'b0;
    intf.fillFlush = 1'b0;
  endtask

  task automatic do_reset();
    resetL = 1'b0;
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    resetL = 1'b1;
  endtask

  task automatic test_reset();
    resetL = 1'b0;
    tick(1'b1, 32'hAAAA_0001, 1'b1, 1'b1);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    resetL = 1'b1;
    checks++; if (intf.bufCnt !== 4'd0) begin errors++; $display("FAIL reset_bufCnt got %0d want 0", intf.bufCnt); end
    checks++; if (intf.fetchVld !== 1'b0) begin errors++; $display("FAIL reset_fetchVld got %b want 0", intf.fetchVld); end
    checks++; if (intf.fillRdy !== 1'b1) begin errors++; $display("FAIL reset_fillRdy got %b want 1", intf.fillRdy); end
    checks++; if (intf.lineDone !== 1'b0) begin errors++; $display("FAIL reset_lineDone got %b want 0", intf.lineDone); end
    checks++; if (intf.fetchData !== 32'd0) begin errors++; $display("FAIL reset_fetchData got %h want 0", intf.fetchData); end
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (intf.bufCnt !== 4'd0) begin errors++; $display("FAIL empty_read_bufCnt got %0d want 0", intf.bufCnt); end
  endtask

  task automatic test_fill_full();
    do_reset();
    tick(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    checks++; if (intf.fetchData !== 32'h0000_0001 || intf.fetchVld !== 1'b1) begin
      errors++; $display("FAIL first_visible got %h/%b want 00000001/1", intf.fetchData, intf.fetchVld);
    end
    for (int i = 2; i <= 4; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
    checks++; if (intf.bufCnt !== 4'(m_cnt)) begin errors++; $display("FAIL full_bufCnt got %0d want %0d", intf.bufCnt, m_cnt); end
    checks++; if (intf.fillRdy !== 1'b0) begin errors++; $display("FAIL full_fillRdy got %b want 0", intf.fillRdy); end
    checks++; if (intf.fetchData !== 32'h0000_0001) begin errors++; $display("FAIL full_head got %h want 00000001", intf.fetchData); end
  endtask

  task automatic test_full_rw();
    checks++; if (intf.fetchData !== exp_q[0]) begin errors++; $display("FAIL fullrw_head got %h want %h", intf.fetchData, exp_q[0]); end
    tick(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    checks++; if (intf.bufCnt !== 4'd3) begin errors++; $display("FAIL fullrw_bufCnt got %0d want 3", intf.bufCnt); end
    checks++; if (intf.fillRdy !== 1'b1) begin errors++; $display("FAIL fullrw_fillRdy got %b want 1", intf.fillRdy); end
    while (m_cnt > 0) begin
      checks++; if (intf.fetchData !== exp_q[0]) begin errors++; $display("FAIL drain_data got %h want %h", intf.fetchData, exp_q[0]); end
      tick(1'b0, 32'd0, 1'b1, 1'b0);
    end
    checks++; if (intf.fetchVld !== 1'b0 || intf.fetchData !== 32'd0) begin
      errors++; $display("FAIL drained got %b/%h want 0/0", intf.fetchVld, intf.fetchData);
    end
  endtask

  // Streams one line with each word read the cycle after it was written.
  task automatic run_line(input logic [31:0] base, output int pulses, output int pulse_at);
    pulses   = 0;
    pulse_at = -1;
    tick(1'b1, base, 1'b0, 1'b0);
    for (int i = 1; i <= LW + 1; i++) begin
      if (i <= LW) begin
        checks++; if (intf.fetchData !== exp_q[0]) begin errors++; $display("FAIL line_data got %h want %h", intf.fetchData, exp_q[0]); end
      end
      tick(i < LW, base + 32'(i), i <= LW, 1'b0);
      checks++; if (intf.lineDone !== m_done) begin errors++; $display("FAIL line_done_%0d got %b want %b", i, intf.lineDone, m_done); end
      if (intf.lineDone === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
  endtask

  task automatic test_line_done();
    int pulses, at;
    do_reset();
    run_line(32'h0000_0100, pulses, at);
    checks++; if (pulses !== 1 || at !== LW) begin errors++; $display("FAIL line_pulse got %0d@%0d want 1@%0d", pulses, at, LW); end
    checks++; if (dut.state_q !== 1'b0) begin errors++; $display("FAIL line_idle got %b want 0", dut.state_q); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    tick(1'b1, 32'h77, 1'b1, 1'b1);
    checks++; if (intf.bufCnt !== 4'd0) begin errors++; $display("FAIL flush_bufCnt got %0d want 0", intf.bufCnt); end
    checks++; if (intf.fetchVld !== 1'b0) begin errors++; $display("FAIL flush_fetchVld got %b want 0", intf.fetchVld); end
    checks++; if (intf.lineDone !== 1'b0) begin errors++; $display("FAIL flush_lineDone got %b want 0", intf.lineDone); end
    checks++; if (dut.wcnt_q !== '0 || dut.state_q !== 1'b0) begin errors++; $display("FAIL flush_fsm got %0d/%b want 0/0", dut.wcnt_q, dut.state_q); end
  endtask

  task automatic test_reset_midline();
    int pulses, at;
    do_reset();
    tick(1'b1, 32'h200, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      checks++; if (intf.fetchData !== exp_q[0]) begin errors++; $display("FAIL mid_data got %h want %h", intf.fetchData, exp_q[0]); end
      tick(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
    end
    checks++; if (dut.wcnt_q !== 3'd5) begin errors++; $display("FAIL mid_count got %0d want 5", dut.wcnt_q); end
    resetL = 1'b0;
    tick(1'b1, 32'h2FF, 1'b1, 1'b1);
    resetL = 1'b1;
    checks++; if (dut.wcnt_q !== '0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", dut.wcnt_q); end
    checks++; if (intf.bufCnt !== 4'd0 || intf.fetchData !== 32'd0) begin
      errors++; $display("FAIL mid_reset_buf got %0d/%h want 0/0", intf.bufCnt, intf.fetchData);
    end
    run_line(32'h0000_0300, pulses, at);
    checks++; if (pulses !== 1 || at !== LW) begin errors++; $display("FAIL mid_line_pulse got %0d@%0d want 1@%0d", pulses, at, LW); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 2 * LW + 6; i++) begin
      logic rd;
      rd = (m_cnt > 0);
      if (rd) begin
        checks++; if (intf.fetchData !== exp_q[0]) begin errors++; $display("FAIL b2b_data got %h want %h", intf.fetchData, exp_q[0]); end
      end
      tick(i < 2 * LW, 32'h400 + 32'(i), rd, 1'b0);
      if (intf.lineDone === 1'b1) pulses++;
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic vld, rd, fl;
      vld = ($urandom_range(3) != 0);
      rd  = ($urandom_range(2) != 0);
      fl  = ($urandom_range(59) == 0);
      if (rd && m_cnt > 0) begin
        checks++; if (intf.fetchData !== exp_q[0]) begin errors++; $display("FAIL rnd_data got %h want %h", intf.fetchData, exp_q[0]); end
      end
      tick(vld, $urandom, rd, fl);
      checks++;
      if (intf.bufCnt !== 4'(m_cnt) || intf.lineDone !== m_done ||
          intf.fetchVld !== (m_cnt > 0) || intf.fillRdy !== (m_cnt < DEPTH)) begin
        errors++;
        $display("FAIL rnd_status cyc %0d got cnt=%0d ld=%b vld=%b rdy=%b want cnt=%0d ld=%b", i,
                 intf.bufCnt, intf.lineDone, intf.fetchVld, intf.fillRdy, m_cnt, m_done);
      end
    end
  endtask

`ifdef ICU_RDBUF_PARITY_EN
  task automatic test_parity();
    do_reset();
    intf.fillPar = 1'b1;
    tick(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    intf.fillPar = 1'b0;
    tick(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    checks++; if (intf.fetchParErr !== 1'b1) begin errors++; $display("FAIL par_err got %b want 1", intf.fetchParErr); end
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (intf.fetchParErr !== 1'b0) begin errors++; $display("FAIL par_ok got %b want 0", intf.fetchParErr); end
  endtask
`endif

  initial begin
    intf.fillVld   = 1'b0;
    intf.fillData  = 32'd0;
    intf.fetchRd   = 1'b0;
    intf.fillFlush = 1'b0;
`ifdef ICU_RDBUF_PARITY_EN
    intf.fillPar   = 1'b0;
`endif
    test_reset();
    test_fill_full();
    test_full_rw();
    test_line_done();
    test_flush();
    test_reset_midline();
    test_back_to_back();
    test_random();
`ifdef ICU_RDBUF_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
